rx_frame_ctrl: RTL
==================

# rx_frame_ctrl

Receive-side framing controller for the serial RX path. It synchronises the raw serial line, detects and validates a start bit, and times each data bit to its mid-point. For each data bit it drives a one-cycle `shift_en` and the sampled bit into the downstream `shift_reg_n` (LSB-first, width N), then checks the stop bit and flags frame completion or error. It sits directly upstream of the shift register and owns all bit timing.

## Interface
- `N`, 5: data bits per frame; must equal the downstream shift register width.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; even, ≥4.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd; used only with `RX_FRAME_PARITY_EN`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rstn` in 1: reset is synchronous and active-low.
- `rx` in 1: asynchronous serial line, idle high.
- `sample_bit` out 1: sampled data bit; drives shift register `data_in`.
- `shift_en` out 1: one-cycle pulse per data bit; drives shift register `shift_en`.
- `rx_done` out 1: one-cycle pulse when the stop bit is valid; shift register contents are a complete frame.
- `frame_err` out 1: one-cycle pulse when the stop bit samples 0.
- `busy` out 1: high in any state other than IDLE.
- `parity_err` out 1: present only with `RX_FRAME_PARITY_EN`; one-cycle pulse, coincident with `rx_done`.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. All decisions use `rx_s` only.
- Bit timer: down-counter, width `$clog2(CLKS_PER_BIT)`. It loads on each state entry and on each bit boundary. A terminal-count (tc) pulse marks a sample point.
- States:
  - IDLE: `rx_s`==0 → START, timer loaded with `CLKS_PER_BIT/2-1`.
  - START: at tc, `rx_s`==0 → DATA with bit index 0 and timer `CLKS_PER_BIT-1`. `rx_s`==1 at tc is a false start → IDLE with no output pulse.
  - DATA: at each tc, register `sample_bit`←`rx_s` and pulse `shift_en`; increment the bit index. After bit N-1 → PARITY if enabled, else STOP.
  - PARITY (macro only): at tc, sample the parity bit → STOP.
  - STOP: at tc, `rx_s`==1 → pulse `rx_done` → IDLE. `rx_s`==0 → pulse `frame_err` → BREAK.
  - BREAK: wait for `rx_s`==1 → IDLE. This prevents a held-low line from retriggering the receiver.
- Bit index width is `$clog2(N+1)`; it never wraps mid-frame.
- `rx` edges inside a bit period are ignored. Only tc samples matter.
- Reset values: all outputs 0, state IDLE, timer 0, bit index 0, synchroniser flops 1.
- `rstn` low mid-frame aborts the frame on the next edge. No `rx_done` or `frame_err` is produced for the aborted frame. Downstream contents are don't-care.

## Timing
- Let edge E0 be the first clk edge at which IDLE sees `rx_s`==0. Edge E0 itself is 2 edges after the `rx` fall, due to the synchroniser.
- Start check at E0+`CLKS_PER_BIT/2`.
- Data bit k is sampled at E0+`CLKS_PER_BIT/2`+`CLKS_PER_BIT`·(k+1). `shift_en` and `sample_bit` are registered and valid in the cycle after that edge.
- Stop sample at E0+`CLKS_PER_BIT/2`+`CLKS_PER_BIT`·(N+1), plus one more `CLKS_PER_BIT` with parity. `rx_done`/`frame_err` are high in the following cycle.
- The shift register holds the full frame in the cycle `rx_done` is high and remains stable until the next `shift_en`.
- Back-to-back frames: a new start bit immediately after the stop sample is accepted. IDLE is re-entered the cycle after the stop pulse.

## Configuration
- `RX_FRAME_PARITY_EN` defined:
  - The PARITY state and the `parity_err` port exist.
  - Parity is the XOR of the N data bits and the parity bit, compared against `PARITY_ODD`.
  - `parity_err` is raised together with `rx_done` on mismatch.
  - A stop-bit error takes precedence: `frame_err` only, no `parity_err`.
- Not defined: no PARITY state and no `parity_err` port. STOP follows data bit N-1 directly.

## Structure
- Package `rx_pkg`: state enum typedef (IDLE, START, DATA, PARITY, STOP, BREAK) and default `CLKS_PER_BIT` constant.
- Sub-module `rx_bit_timer`: loadable down-counter with a tc output, parameterised by `CLKS_PER_BIT`.
- Synchroniser and FSM are in the top level.

## Test plan
- N=5, `CLKS_PER_BIT`=16, frame 0x15 (bits 1,0,1,0,1, stop 1) → exactly 5 `shift_en` pulses with `sample_bit` 1,0,1,0,1, one `rx_done`. Shift register reads 5'h15; `frame_err` stays 0.
- 4-cycle low glitch on `rx` → false start. No `shift_en`, `busy` back to 0 by E0+9.
- Frame 0x0A with stop bit 0, `rx` held low afterward → `frame_err` pulse, FSM in BREAK. No new frame until `rx` goes high, then frame 0x1F → `rx_done`, shift register reads 5'h1F.
- `rstn` low for 1 cycle after the 3rd `shift_en` → all outputs 0 next cycle. No `rx_done` for that frame; the next clean frame 0x11 is received correctly.
- Two back-to-back frames 0x03 then 0x1C with zero idle time → two `rx_done` pulses, `CLKS_PER_BIT`·(N+2) cycles apart; shift register reads 5'h03 then 5'h1C.
- With `RX_FRAME_PARITY_EN`, `PARITY_ODD`=0: frame 0x07 with parity 1 → `rx_done` only. Same frame with parity 0 → `rx_done` plus `parity_err`.

Source files
------------

// File: rtl/rx_pkg.sv
// rx_pkg: shared types and defaults for the serial RX framing path.
// Optional parity support in the users of this package is selected by RX_FRAME_PARITY_EN.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    localparam int unsigned RX_CLKS_PER_BIT = 16;

    // Reload value that places the first sample point in the middle of the start bit.
    function automatic int unsigned rx_half_bit_load(input int unsigned clks_per_bit);
        return (clks_per_bit / 2) - 1;
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: loadable down-counter for bit timing. tc is high while the
// count is zero; the count parks at zero until the next load.
// Build macro RX_FRAME_PARITY_EN has no effect on this file.
module rx_bit_timer
    import rx_pkg::*;
#(
    parameter  int unsigned CLKS_PER_BIT = RX_CLKS_PER_BIT,
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          tc
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: receive framing controller. Synchronises rx, validates the
// start bit, samples N data bits LSB-first at bit mid-points and drives the
// downstream shift register, then checks the stop bit.
// Build macro RX_FRAME_PARITY_EN adds the PARITY state and the parity_err port.
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter int unsigned N            = 5,
    parameter int unsigned CLKS_PER_BIT = RX_CLKS_PER_BIT,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    output logic sample_bit,
    output logic shift_en,
    output logic rx_done,
    output logic frame_err,
`ifdef RX_FRAME_PARITY_EN
    output logic parity_err,
`endif
    output logic busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(N + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(rx_half_bit_load(CLKS_PER_BIT));
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0) || (PARITY_ODD > 1)) begin : g_cfg_err
        $error("rx_frame_ctrl: CLKS_PER_BIT must be even and >= 4, PARITY_ODD must be 0 or 1");
    end

    logic rx_meta_q;
    logic rx_s_q;

    rx_state_e     state_q,      state_d;
    logic [IW-1:0] bit_idx_q,    bit_idx_d;
    logic          sample_bit_q, sample_bit_d;
    logic          shift_en_q,   shift_en_d;
    logic          rx_done_q,    rx_done_d;
    logic          frame_err_q,  frame_err_d;
`ifdef RX_FRAME_PARITY_EN
    localparam logic PAR_EXP = (PARITY_ODD != 0);
    logic          par_q,        par_d;
    logic          parity_err_q, parity_err_d;
`endif

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_tc;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state, timer control and registered-output logic for the framing FSM.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        sample_bit_d = sample_bit_q;
        shift_en_d   = 1'b0;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = FULL_LOAD;
`ifdef RX_FRAME_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d  = START;
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LOAD;
                end
            end
            START: begin
                if (tmr_tc) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                        tmr_load  = 1'b1;
`ifdef RX_FRAME_PARITY_EN
                        par_d     = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tmr_tc) begin
                    sample_bit_d = rx_s_q;
                    shift_en_d   = 1'b1;
                    bit_idx_d    = bit_idx_q + 1'b1;
                    tmr_load     = 1'b1;
`ifdef RX_FRAME_PARITY_EN
                    par_d        = par_q ^ rx_s_q;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end
`else
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
`endif
                end
            end
`ifdef RX_FRAME_PARITY_EN
            PARITY: begin
                if (tmr_tc) begin
                    par_d    = par_q ^ rx_s_q;
                    tmr_load = 1'b1;
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (tmr_tc) begin
                    if (rx_s_q) begin
                        rx_done_d    = 1'b1;
`ifdef RX_FRAME_PARITY_EN
                        parity_err_d = (par_q != PAR_EXP);
`endif
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            bit_idx_q    <= '0;
            sample_bit_q <= 1'b0;
            shift_en_q   <= 1'b0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef RX_FRAME_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            sample_bit_q <= sample_bit_d;
            shift_en_q   <= shift_en_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
`ifdef RX_FRAME_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign sample_bit = sample_bit_q;
    assign shift_en   = shift_en_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);
`ifdef RX_FRAME_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
